// File: rtl/witf_pkg.sv
// Write-in-flight table: shared register-index defines and entry helpers.
// Optional retire bypass is enabled with WITF_RETIRE_BYPASS_EN.
`ifndef WITF_DEFINES_SVH
`define WITF_DEFINES_SVH
`define RegAddrBus 4:0
`define WITF_DEPTH 4
`define WITF_ENTRY_W 6
`endif

package witf_pkg;
   localparam int REG_W   = 5;
   localparam int ENTRY_W = `WITF_ENTRY_W;

   // Entry layout: {valid, rd[4:0]}
   function automatic logic entry_valid(input logic [ENTRY_W-1:0] e);
      return e[ENTRY_W-1];
   endfunction

   function automatic logic [`RegAddrBus] entry_rd(input logic [ENTRY_W-1:0] e);
      return e[REG_W-1:0];
   endfunction

   function automatic logic [ENTRY_W-1:0] make_entry(input logic [`RegAddrBus] rd);
      return {1'b1, rd};
   endfunction
endpackage

// File: rtl/witf_if.sv
// Decode/writeback <-> write-in-flight table signal bundle.
interface witf_if #(
   parameter int DEPTH = `WITF_DEPTH
);
   localparam int PTR_W = $clog2(DEPTH);

   logic               disp_en;
   logic [`RegAddrBus] rd;
   logic [`RegAddrBus] rs1;
   logic [`RegAddrBus] rs2;
   logic               wb_en;
   logic [`RegAddrBus] wb_rd;
   logic               isRAW;
   logic               witf_full;
   logic               witf_empty;
   logic [PTR_W:0]     witf_cnt;
   logic               witf_err;

   modport master (
      output disp_en, rd, rs1, rs2, wb_en, wb_rd,
      input  isRAW, witf_full, witf_empty, witf_cnt, witf_err
   );

   modport slave (
      input  disp_en, rd, rs1, rs2, wb_en, wb_rd,
      output isRAW, witf_full, witf_empty, witf_cnt, witf_err
   );
endinterface

// File: rtl/witf_cmp.sv
// Per-entry RAW comparator: hit when a live, non-killed entry matches a nonzero source.
module witf_cmp
   import witf_pkg::*;
(
   input  logic [ENTRY_W-1:0] entry,
   input  logic [`RegAddrBus] rs1,
   input  logic [`RegAddrBus] rs2,
   input  logic               kill,
   output logic               hit
);
   logic [`RegAddrBus] erd;
   logic               m1;
   logic               m2;

   assign erd = entry_rd(entry);
   assign m1  = (rs1 != '0) && (rs1 == erd);
   assign m2  = (rs2 != '0) && (rs2 == erd);
   assign hit = entry_valid(entry) && !kill && (m1 || m2);
endmodule

// File: rtl/witf.sv
// Write-in-flight table: in-order circular scoreboard of pending destination registers.
// Define WITF_RETIRE_BYPASS_EN to exclude the retiring head entry from the RAW compare.
module witf
   import witf_pkg::*;
#(
   parameter int DEPTH = `WITF_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   witf_if.slave bus
);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] entry_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               err_q;

   logic               full;
   logic               empty;
   logic               do_disp;
   logic               do_ret;
   logic               proto_err;
   logic [ENTRY_W-1:0] head;
   logic [DEPTH-1:0]   kill;
   logic [DEPTH-1:0]   hit;

   // Status comes from registered count only, so a same-cycle retire never frees a full slot.
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign head    = entry_q[rd_ptr_q];
   assign do_disp = bus.disp_en && !full && (bus.rd != '0);
   assign do_ret  = bus.wb_en && !empty;

   assign proto_err = (bus.disp_en && full) || (bus.wb_en && empty) ||
                      (do_ret && (bus.wb_rd != entry_rd(head)));

   // NOTE: the entry array is reset because its valid bits feed isRAW combinationally;
   // an unreset valid bit would raise phantom hazards after power-up.
   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (do_disp) begin
            entry_q[wr_ptr_q] <= make_entry(bus.rd);
            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
         end
         if (do_ret) begin
            entry_q[rd_ptr_q][ENTRY_W-1] <= 1'b0;
            rd_ptr_q                     <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_disp, do_ret})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (proto_err) err_q <= 1'b1;
      end
   end

`ifdef WITF_RETIRE_BYPASS_EN
   // NOTE: default first so no path through this block can infer a latch.
   always_comb begin
      kill           = '0;
      kill[rd_ptr_q] = do_ret;
   end
`else
   assign kill = '0;
`endif

   for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      witf_cmp u_cmp (
         .entry (entry_q[g]),
         .rs1   (bus.rs1),
         .rs2   (bus.rs2),
         .kill  (kill[g]),
         .hit   (hit[g])
      );
   end

   assign bus.isRAW      = |hit;
   assign bus.witf_full  = full;
   assign bus.witf_empty = empty;
   assign bus.witf_cnt   = cnt_q;
   assign bus.witf_err   = err_q;
endmodule
